// File: rtl/mega_alu_wb_pkg.sv
// Shared writeback definitions: transaction kinds, SREG bit indices, FSM states.
package mega_alu_wb_pkg;

    typedef enum logic [1:0] {
        WB_KIND_NONE = 2'd0,
        WB_KIND_BYTE = 2'd1,
        WB_KIND_WORD = 2'd2,
        WB_KIND_MUL  = 2'd3
    } wb_kind_e;

    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;
    localparam int SREG_S = 4;
    localparam int SREG_H = 5;
    localparam int SREG_T = 6;
    localparam int SREG_I = 7;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WR_LO = 2'd1,
        WB_WR_HI = 2'd2
    } wb_state_e;

endpackage

// File: rtl/mega_alu_wb_if.sv
// ALU-to-writeback result handshake bundle.
interface mega_alu_wb_if;
    import mega_alu_wb_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [4:0]  in_rd;
    logic [1:0]  in_kind;
    logic [7:0]  in_flags;
    logic [7:0]  in_flag_mask;

    modport master (
        output in_valid, in_data, in_rd, in_kind,
        output in_flags, in_flag_mask,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_data, in_rd, in_kind,
        input  in_flags, in_flag_mask,
        output in_ready
    );

endinterface

// File: rtl/mega_alu_wb_sreg.sv
// mega_sreg: architectural SREG with masked flag merge; I/O writes win.
module mega_sreg #(
    parameter logic [7:0] SREG_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd,
    input  logic [7:0] flags,
    input  logic [7:0] mask,
    input  logic       io_we,
    input  logic [7:0] io_data,
    output logic [7:0] sreg
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= SREG_RST;
        end else if (io_we) begin
            sreg <= io_data;
        end else if (upd) begin
            sreg <= (sreg & ~mask) | (flags & mask);
        end
    end

endmodule

// File: rtl/mega_alu_wb.sv
// Writeback stage: SREG merge and byte-wide RF write port, 16-bit results split.
// Optional MEGA_ALU_WB_WORD_PORT_EN adds a high-byte port for one-cycle word writes.
module mega_alu_wb
    import mega_alu_wb_pkg::*;
#(
    parameter logic [7:0] SREG_RST    = 8'h00,
    parameter logic [4:0] MUL_LO_ADDR = 5'd0
) (
    input  logic          clk,
    input  logic          rst,
    mega_alu_wb_if.slave  alu,
    input  logic          sreg_io_we,
    input  logic [7:0]    sreg_io_data,
    output logic [7:0]    sreg,
    output logic          rf_we,
    output logic [4:0]    rf_addr,
    output logic [7:0]    rf_wdata,
    output logic          done
`ifdef MEGA_ALU_WB_WORD_PORT_EN
    ,
    output logic          rf_we_hi,
    output logic [7:0]    rf_wdata_hi
`endif
);

    wb_state_e  state_q, state_d;
    wb_kind_e   kind;
    logic       accept;
    logic       word_q, word_d;
    logic [4:0] hi_addr_q, hi_addr_d;
    logic [7:0] hi_data_q, hi_data_d;
    logic [4:0] lo_addr;
    logic       we_d, done_d;
    logic [4:0] addr_d;
    logic [7:0] wdata_d;

    assign kind    = wb_kind_e'(alu.in_kind);
    assign accept  = alu.in_valid & alu.in_ready;
    assign lo_addr = (kind == WB_KIND_MUL) ? MUL_LO_ADDR
                                           : {alu.in_rd[4:1], 1'b0};

`ifdef MEGA_ALU_WB_WORD_PORT_EN
    logic       we_hi_d;
    logic [7:0] wdata_hi_d;

    assign alu.in_ready = 1'b1;
`else
    // A pending high byte blocks accept only while its low byte is out.
    assign alu.in_ready = (state_q == WB_IDLE)
                        | ((state_q == WB_WR_LO) & ~word_q)
                        | (state_q == WB_WR_HI);
`endif

    always_comb begin
        state_d   = WB_IDLE;
        word_d    = 1'b0;
        hi_addr_d = hi_addr_q;
        hi_data_d = hi_data_q;
        we_d      = 1'b0;
        addr_d    = rf_addr;
        wdata_d   = rf_wdata;
        done_d    = 1'b0;
`ifdef MEGA_ALU_WB_WORD_PORT_EN
        we_hi_d    = 1'b0;
        wdata_hi_d = rf_wdata_hi;
`endif
        if (accept) begin
            case (kind)
                WB_KIND_NONE: begin
                    done_d = 1'b1;
                end
                WB_KIND_BYTE: begin
                    state_d = WB_WR_LO;
                    we_d    = 1'b1;
                    addr_d  = alu.in_rd;
                    wdata_d = alu.in_data[7:0];
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = WB_WR_LO;
                    we_d    = 1'b1;
                    addr_d  = lo_addr;
                    wdata_d = alu.in_data[7:0];
`ifdef MEGA_ALU_WB_WORD_PORT_EN
                    we_hi_d    = 1'b1;
                    wdata_hi_d = alu.in_data[15:8];
                    done_d     = 1'b1;
`else
                    word_d    = 1'b1;
                    hi_addr_d = lo_addr + 5'd1;
                    hi_data_d = alu.in_data[15:8];
`endif
                end
            endcase
        end else if (state_q == WB_WR_LO && word_q) begin
            state_d = WB_WR_HI;
            we_d    = 1'b1;
            addr_d  = hi_addr_q;
            wdata_d = hi_data_q;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_addr_q <= 5'd0;
            hi_data_q <= 8'h00;
            rf_we     <= 1'b0;
            rf_addr   <= 5'd0;
            rf_wdata  <= 8'h00;
            done      <= 1'b0;
        end else begin
            hi_addr_q <= hi_addr_d;
            hi_data_q <= hi_data_d;
            rf_we     <= we_d;
            rf_addr   <= addr_d;
            rf_wdata  <= wdata_d;
            done      <= done_d;
        end
    end

`ifdef MEGA_ALU_WB_WORD_PORT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_hi    <= 1'b0;
            rf_wdata_hi <= 8'h00;
        end else begin
            rf_we_hi    <= we_hi_d;
            rf_wdata_hi <= wdata_hi_d;
        end
    end
`endif

    mega_sreg #(
        .SREG_RST (SREG_RST)
    ) u_sreg (
        .clk     (clk),
        .rst     (rst),
        .upd     (accept),
        .flags   (alu.in_flags),
        .mask    (alu.in_flag_mask),
        .io_we   (sreg_io_we),
        .io_data (sreg_io_data),
        .sreg    (sreg)
    );

endmodule

// File: tb/tb_mega_alu_wb.sv
// Directed bench for mega_alu_wb: byte, word, MUL back-to-back, flags, reset.
module tb_mega_alu_wb;
    import mega_alu_wb_pkg::*;

    logic       clk;
    logic       rst;
    logic       sreg_io_we;
    logic [7:0] sreg_io_data;
    logic [7:0] sreg;
    logic       rf_we;
    logic [4:0] rf_addr;
    logic [7:0] rf_wdata;
    logic       done;
`ifdef MEGA_ALU_WB_WORD_PORT_EN
    logic       rf_we_hi;
    logic [7:0] rf_wdata_hi;
`endif

    int checks;
    int failures;

    mega_alu_wb_if bus ();

    mega_alu_wb dut (
        .clk          (clk),
        .rst          (rst),
        .alu          (bus.slave),
        .sreg_io_we   (sreg_io_we),
        .sreg_io_data (sreg_io_data),
        .sreg         (sreg),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_wdata     (rf_wdata),
        .done         (done)
`ifdef MEGA_ALU_WB_WORD_PORT_EN
        ,
        .rf_we_hi     (rf_we_hi),
        .rf_wdata_hi  (rf_wdata_hi)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] k,
                         input logic [4:0] rd, input logic [15:0] d,
                         input logic [7:0] f, input logic [7:0] m);
        bus.in_valid     = v;
        bus.in_kind      = k;
        bus.in_rd        = rd;
        bus.in_data      = d;
        bus.in_flags     = f;
        bus.in_flag_mask = m;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 5'd0, 16'h0000, 8'h00, 8'h00);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        sreg_io_we   = 1'b0;
        sreg_io_data = 8'h00;
        idle();
        cyc();
        rst = 1'b0;
        chk("rst_sreg", {8'h0, sreg}, 16'h0000);
        chk("rst_we", {15'h0, rf_we}, 16'h0000);
        chk("rst_done", {15'h0, done}, 16'h0000);
        chk("rst_ready", {15'h0, bus.in_ready}, 16'h0001);

        // byte write
        drive(1'b1, 2'd1, 5'd5, 16'h12A5, 8'h00, 8'h00);
        cyc();
        idle();
        chk("byte_we", {15'h0, rf_we}, 16'h0001);
        chk("byte_addr", {11'h0, rf_addr}, 16'd5);
        chk("byte_data", {8'h0, rf_wdata}, 16'h00A5);
        chk("byte_done", {15'h0, done}, 16'h0001);
        cyc();
        chk("byte_we_off", {15'h0, rf_we}, 16'h0000);
        chk("byte_done_off", {15'h0, done}, 16'h0000);

        // word pair from odd rd
        drive(1'b1, 2'd2, 5'd25, 16'hBEEF, 8'h00, 8'h00);
        cyc();
        idle();
        chk("wlo_we", {15'h0, rf_we}, 16'h0001);
        chk("wlo_addr", {11'h0, rf_addr}, 16'd24);
        chk("wlo_data", {8'h0, rf_wdata}, 16'h00EF);
        chk("wlo_done", {15'h0, done}, 16'h0000);
        chk("wlo_ready", {15'h0, bus.in_ready}, 16'h0000);
        cyc();
        chk("whi_we", {15'h0, rf_we}, 16'h0001);
        chk("whi_addr", {11'h0, rf_addr}, 16'd25);
        chk("whi_data", {8'h0, rf_wdata}, 16'h00BE);
        chk("whi_done", {15'h0, done}, 16'h0001);
        cyc();
        chk("word_we_off", {15'h0, rf_we}, 16'h0000);

        // MUL pair then byte with no bubble
        drive(1'b1, 2'd3, 5'd17, 16'h0C00, 8'h00, 8'h00);
        cyc();
        drive(1'b1, 2'd1, 5'd3, 16'h0077, 8'h00, 8'h00);
        chk("mul_lo_addr", {11'h0, rf_addr}, 16'd0);
        chk("mul_lo_data", {8'h0, rf_wdata}, 16'h0000);
        chk("mul_lo_done", {15'h0, done}, 16'h0000);
        cyc();
        chk("mul_hi_we", {15'h0, rf_we}, 16'h0001);
        chk("mul_hi_addr", {11'h0, rf_addr}, 16'd1);
        chk("mul_hi_data", {8'h0, rf_wdata}, 16'h000C);
        chk("mul_hi_done", {15'h0, done}, 16'h0001);
        chk("mul_hi_ready", {15'h0, bus.in_ready}, 16'h0001);
        cyc();
        idle();
        chk("b2b_we", {15'h0, rf_we}, 16'h0001);
        chk("b2b_addr", {11'h0, rf_addr}, 16'd3);
        chk("b2b_data", {8'h0, rf_wdata}, 16'h0077);
        chk("b2b_done", {15'h0, done}, 16'h0001);
        cyc();
        chk("b2b_we_off", {15'h0, rf_we}, 16'h0000);
        chk("sreg_untouched", {8'h0, sreg}, 16'h0000);

        // I/O write alone, then masked merge, then I/O wins
        sreg_io_we   = 1'b1;
        sreg_io_data = 8'hFF;
        cyc();
        sreg_io_we = 1'b0;
        chk("io_sreg", {8'h0, sreg}, 16'h00FF);
        chk("io_we_none", {15'h0, rf_we}, 16'h0000);
        drive(1'b1, 2'd0, 5'd0, 16'h0000, 8'h01, 8'h03);
        cyc();
        idle();
        chk("flag_sreg", {8'h0, sreg}, 16'h00FD);
        chk("flag_done", {15'h0, done}, 16'h0001);
        chk("flag_we", {15'h0, rf_we}, 16'h0000);
        drive(1'b1, 2'd0, 5'd0, 16'h0000, 8'h01, 8'h03);
        sreg_io_we   = 1'b1;
        sreg_io_data = 8'h80;
        cyc();
        idle();
        sreg_io_we = 1'b0;
        chk("io_wins", {8'h0, sreg}, 16'h0080);
        cyc();
        chk("flag_done_off", {15'h0, done}, 16'h0000);

        // reset during low-byte cycle of a word
        drive(1'b1, 2'd2, 5'd10, 16'h1234, 8'h5A, 8'hFF);
        cyc();
        idle();
        chk("mid_sreg", {8'h0, sreg}, 16'h005A);
        chk("mid_lo_addr", {11'h0, rf_addr}, 16'd10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_we", {15'h0, rf_we}, 16'h0000);
        chk("mid_rst_done", {15'h0, done}, 16'h0000);
        chk("mid_rst_sreg", {8'h0, sreg}, 16'h0000);
        chk("mid_rst_ready", {15'h0, bus.in_ready}, 16'h0001);
        cyc();
        chk("mid_no_hi", {15'h0, rf_we}, 16'h0000);
        chk("mid_no_done", {15'h0, done}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
